// File: rtl/a2d_arb_pkg.sv
// Shared constants for the A2D arbiter: FSM state encoding and requester indices.
package a2d_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam int NUM_REQ    = 2;
  localparam int REQ_MOTION = 0;
  localparam int REQ_HK     = 1;

endpackage

// File: rtl/a2d_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: one-hot grant, favouring the
// requester that was not served last when both are asking.
module rr_arb2
  import a2d_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_served,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_served ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/a2d_arbiter.sv
// Shares one A2D converter between the motion controller and housekeeping,
// with round-robin grants and a watchdog that aborts hung conversions.
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int RES_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [2:0]         chnnl0,
  input  logic [2:0]         chnnl1,
  input  logic               cnv_cmplt,
  input  logic [RES_W-1:0]   A2D_res,
  output logic               strt_cnv,
  output logic [2:0]         chnnl,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic [RES_W-1:0]   res,
  output logic               err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             last_served;
  logic [1:0]       pick;
  logic             timeout_hit;

  rr_arb2 u_rr_arb2 (
    .req         (req),
    .last_served (last_served),
    .gnt         (pick)
  );

  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // last_served resets to 1 so requester 0 wins the first contended pick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      last_served <= 1'b1;
      strt_cnv    <= 1'b0;
      chnnl       <= '0;
      gnt         <= '0;
      done        <= '0;
      res         <= '0;
      err         <= 1'b0;
    end else begin
      strt_cnv <= 1'b0;
      done     <= '0;
      case (state)
        IDLE: begin
          if (|pick) begin
            gnt      <= pick;
            chnnl    <= pick[REQ_MOTION] ? chnnl0 : chnnl1;
            strt_cnv <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // a completion arriving on the timeout cycle still counts as success
          if (cnv_cmplt) begin
            res   <= A2D_res;
            err   <= 1'b0;
            done  <= gnt;
            state <= DONE;
          end else if (timeout_hit) begin
            res   <= '0;
            err   <= 1'b1;
            done  <= gnt;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          last_served <= gnt[REQ_HK];
          gnt         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
